// File: rtl/cache_write_buffer.sv
// rtl/cache_write_buffer.sv - in-order store buffer with coalescing, store-to-load forwarding and req/ack drain
module cache_write_buffer #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    write,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   write_data,
  output logic                    write_ready,
  input  logic [ADDR_WIDTH-1:0]   lookup_addr,
  output logic                    fwd_hit,
  output logic [DATA_WIDTH-1:0]   fwd_data,
  output logic                    mem_req,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_ack,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full,
  output logic                    drop_err
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [PW:0]           r_count;
  logic                  r_drop_err;

  logic [PW-1:0]         w_youngest;
  logic                  w_full;
  logic                  w_mem_req;
  logic                  w_accept;
  logic                  w_coalesce;
  logic                  w_push;
  logic                  w_pop;
  logic [PW:0]           w_count_next;
  logic                  w_hit;
  logic [DATA_WIDTH-1:0] w_fwd_data;

  assign w_full     = (r_count == (PW+1)'(DEPTH));
  assign w_youngest = r_tail - PW'(1);
  assign w_accept   = write && !w_full;
  // The head under presentation must never change, so only a non-presented youngest entry may merge.
  assign w_coalesce = w_accept && (r_count != '0) && (r_addr[w_youngest] == addr)
                      && !(w_mem_req && (r_count == (PW+1)'(1)));
  assign w_push       = w_accept && !w_coalesce;
  assign w_pop        = w_mem_req && mem_ack;
  assign w_count_next = r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (r_count != '0) w_state_next = S_REQ;
      S_REQ:   if (w_pop && (w_count_next == '0)) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_mem_req = (r_state == S_REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_drop_err <= 1'b0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      r_count <= w_count_next;
      if (write && !w_accept) r_drop_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= addr;
      r_data[r_tail] <= write_data;
    end else if (w_coalesce) begin
      r_data[w_youngest] <= write_data;
    end
  end

  // Scan oldest to youngest so the last match, the youngest, wins.
  always_comb begin
    w_hit      = 1'b0;
    w_fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((k < int'(r_count)) && (r_addr[r_head + PW'(k)] == lookup_addr)) begin
        w_hit      = 1'b1;
        w_fwd_data = r_data[r_head + PW'(k)];
      end
    end
  end

  assign write_ready = !w_full;
  assign fwd_hit     = w_hit;
  assign fwd_data    = w_fwd_data;
  assign mem_req     = w_mem_req;
  assign mem_addr    = w_mem_req ? r_addr[r_head] : '0;
  assign mem_wdata   = w_mem_req ? r_data[r_head] : '0;
  assign count       = r_count;
  assign empty       = (r_count == '0);
  assign full        = w_full;
  assign drop_err    = r_drop_err;

endmodule
